// File: rtl/matrix_tile_reader.sv
// Walks a tile of rows in a linear scratch memory and emits each row as one vector.
// Elements are fetched one per cycle; a row is held on the output stream until it is accepted.
module matrix_tile_reader #(
  parameter int DATA_WIDTH   = 8,
  parameter int SIZE         = 1024,
  parameter int ADDRESS_BITS = $clog2(SIZE + 1),
  parameter int VEC_LEN      = 4,
  parameter int COUNT_BITS   = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [ADDRESS_BITS-1:0]       cmd_base_address,
  input  logic [COUNT_BITS-1:0]         cmd_row_count,
  input  logic [COUNT_BITS-1:0]         cmd_row_stride,
  output logic [ADDRESS_BITS-1:0]       read_address,
  input  logic [DATA_WIDTH-1:0]         read_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [VEC_LEN*DATA_WIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
);
  localparam int EW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [EW-1:0] ELEM_LAST = EW'(VEC_LEN - 1);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;

  state_t                  state_q;
  logic [ADDRESS_BITS-1:0] row_addr_q;
  logic [ADDRESS_BITS-1:0] addr_q;
  logic [COUNT_BITS-1:0]   count_q;
  logic [COUNT_BITS-1:0]   stride_q;
  logic [COUNT_BITS-1:0]   row_idx_q;
  logic [EW-1:0]           elem_idx_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic                    done_q;
  logic [DATA_WIDTH-1:0]   slot_q [VEC_LEN];

  logic                    cmd_fire;
  logic                    out_fire;
  logic [ADDRESS_BITS-1:0] next_row_addr_d;

  assign cmd_fire        = cmd_valid && (state_q == IDLE);
  assign out_fire        = out_valid_q && out_ready;
  assign next_row_addr_d = row_addr_q + ADDRESS_BITS'(stride_q);

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign done         = done_q;
  assign read_address = addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      row_addr_q  <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      stride_q    <= '0;
      row_idx_q   <= '0;
      elem_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            count_q    <= cmd_row_count;
            stride_q   <= cmd_row_stride;
            row_addr_q <= cmd_base_address;
            row_idx_q  <= '0;
            elem_idx_q <= '0;
            // An empty tile completes without touching the memory address.
            if (cmd_row_count == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= cmd_base_address;
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          elem_idx_q <= elem_idx_q + EW'(1);
          if (elem_idx_q == ELEM_LAST) begin
            state_q     <= EMIT;
            out_valid_q <= 1'b1;
            out_last_q  <= (row_idx_q == count_q - COUNT_BITS'(1));
          end else begin
            addr_q <= addr_q + ADDRESS_BITS'(1);
          end
        end
        EMIT: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              row_addr_q <= next_row_addr_d;
              addr_q     <= next_row_addr_d;
              row_idx_q  <= row_idx_q + COUNT_BITS'(1);
              elem_idx_q <= '0;
              state_q    <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Vector slots stay frozen outside FETCH, so the emitted row holds until accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < VEC_LEN; i++) slot_q[i] <= '0;
    end else if (state_q == FETCH) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        if (elem_idx_q == EW'(i)) slot_q[i] <= read_data;
      end
    end
  end

  for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_out
    assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q[gi];
  end

endmodule

// File: tb/tb_matrix_tile_reader.sv
// Scoreboard bench for matrix_tile_reader: tiles are expanded into expected addresses and rows
// by plain arithmetic; a negedge monitor pops and compares whatever the DUT presents.
module tb_matrix_tile_reader;
  localparam int DW   = 8;
  localparam int SIZE = 1024;
  localparam int AB   = 11;
  localparam int VL   = 4;
  localparam int CB   = 8;
  localparam int AMOD = 1 << AB;

  typedef logic [VL*DW-1:0] vec_t;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [AB-1:0]  cmd_base_address = '0;
  logic [CB-1:0]  cmd_row_count = '0;
  logic [CB-1:0]  cmd_row_stride = '0;
  logic [AB-1:0]  read_address;
  logic [DW-1:0]  read_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  vec_t           out_data;
  logic           out_last;
  logic           busy;
  logic           done;

  logic [DW-1:0]  mem [AMOD];
  assign read_data = mem[read_address];

  always #5 clk = ~clk;

  matrix_tile_reader #(
    .DATA_WIDTH(DW), .SIZE(SIZE), .ADDRESS_BITS(AB), .VEC_LEN(VL), .COUNT_BITS(CB)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_address(cmd_base_address), .cmd_row_count(cmd_row_count),
    .cmd_row_stride(cmd_row_stride),
    .read_address(read_address), .read_data(read_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  int   tests = 0;
  int   fails = 0;
  vec_t exp_row_q [$];
  bit   exp_last_q [$];
  int   exp_addr_q [$];
  int   done_pending = 0;
  int   ready_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  // Reference model: row r element j lives at (base + r*stride + j) mod 2^AB.
  task automatic push_tile(input int base, input int count, input int stride);
    for (int r = 0; r < count; r++) begin
      vec_t v;
      v = '0;
      for (int j = 0; j < VL; j++) begin
        int a;
        a = (base + r * stride + j) % AMOD;
        exp_addr_q.push_back(a);
        v[j*DW +: DW] = mem[a];
      end
      exp_row_q.push_back(v);
      exp_last_q.push_back(r == count - 1);
    end
    done_pending++;
  endtask

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  bit            pv, pr, pl;
  vec_t          pd;
  logic [AB-1:0] pa;

  always @(negedge clk) begin
    if (!reset_n) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(pd));
        chk("hold_last", 64'(out_last), 64'(pl));
        chk("hold_addr", 64'(read_address), 64'(pa));
      end
      chk("cmd_ready_vs_busy", 64'(cmd_ready), 64'(!busy));
      if (busy && !out_valid) begin
        if (exp_addr_q.size() == 0) fail_event("read_address_extra");
        else chk("read_address", 64'(read_address), 64'(exp_addr_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_row_q.size() == 0) fail_event("row_extra");
        else begin
          chk("row_data", 64'(out_data), 64'(exp_row_q.pop_front()));
          chk("row_last", 64'(out_last), 64'(exp_last_q.pop_front()));
        end
      end
      if (done) begin
        if (done_pending == 0) fail_event("done_extra");
        else done_pending--;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last; pa = read_address;
    end
  end

  task automatic issue(input int base, input int count, input int stride);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    push_tile(base, count, stride);
    cmd_valid        = 1'b1;
    cmd_base_address = base[AB-1:0];
    cmd_row_count    = count[CB-1:0];
    cmd_row_stride   = stride[CB-1:0];
    @(posedge clk); #1;
    cmd_valid        = 1'b0;
    cmd_base_address = AB'($urandom);
    cmd_row_count    = CB'($urandom);
    cmd_row_stride   = CB'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done_pending != 0) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < AMOD; i++) mem[i] = DW'(i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int v0, v1, dn, hs, lasts, seen_busy, seen_valid, dpulses;
    logic [AB-1:0] addr_before;
    vec_t first_row;

    fill_linear();
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_read_address", 64'(read_address), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Basic timing: rows valid in cycles 5 and 10, done in 11.
    ready_mode = 0;
    issue(0, 2, 4);
    v0 = -1; v1 = -1; dn = -1;
    first_row = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (out_valid && v0 < 0) begin v0 = k; first_row = out_data; end
      if (out_valid && out_last && v1 < 0) v1 = k;
      if (done && dn < 0) dn = k;
    end
    chk("t1_row0_cycle", 64'(v0), 64'd5);
    chk("t1_row0_data", 64'(first_row), 64'h03020100);
    chk("t1_row1_cycle", 64'(v1), 64'd10);
    chk("t1_done_cycle", 64'(dn), 64'd11);
    wait_idle();

    // Back-pressure on row 0 for six cycles.
    ready_mode = 2;
    issue(0, 2, 4);
    v0 = 0;
    while (!out_valid && v0 < 20) begin @(negedge clk); v0++; end
    chk("t2_valid_seen", 64'(out_valid), 64'd1);
    repeat (6) @(negedge clk);
    ready_mode = 0;
    hs = 0;
    while (!(out_valid && out_ready) && hs < 20) begin @(negedge clk); hs++; end
    @(negedge clk);
    chk("t2_refetch_busy", 64'(busy && !out_valid), 64'd1);
    chk("t2_refetch_addr", 64'(read_address), 64'd4);
    wait_idle();

    // Empty tile.
    addr_before = read_address;
    issue(17, 0, 5);
    dn = -1; seen_busy = 0; seen_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (done && dn < 0) dn = k;
      if (busy) seen_busy = 1;
      if (out_valid) seen_valid = 1;
    end
    chk("t3_done_cycle", 64'(dn), 64'd1);
    chk("t3_busy_seen", 64'(seen_busy), 64'd0);
    chk("t3_valid_seen", 64'(seen_valid), 64'd0);
    chk("t3_addr_unchanged", 64'(read_address), 64'(addr_before));
    wait_idle();

    // Address wrap at the address-width boundary.
    issue(2046, 1, 0);
    v0 = 0;
    while (!out_valid && v0 < 20) begin @(negedge clk); v0++; end
    chk("t4_wrap_row", 64'(out_data), 64'h0100FFFE);
    chk("t4_wrap_last", 64'(out_last), 64'd1);
    wait_idle();

    // Zero stride: three identical rows, last flag only on the third.
    issue(8, 3, 0);
    hs = 0; lasts = 0; v1 = -1;
    for (int k = 0; k < 40 && (busy || k == 0); k++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        hs++;
        if (out_last) begin lasts++; v1 = hs; end
        chk("t5_row_data", 64'(out_data), 64'h0B0A0908);
      end
    end
    chk("t5_rows", 64'(hs), 64'd3);
    chk("t5_last_count", 64'(lasts), 64'd1);
    chk("t5_last_position", 64'(v1), 64'd3);
    wait_idle();

    // Reset in the third FETCH cycle abandons the tile.
    issue(0, 3, 4);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_last", 64'(out_last), 64'd0);
    chk("t6_out_data", 64'(out_data), 64'd0);
    chk("t6_read_address", 64'(read_address), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    exp_row_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    done_pending = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dpulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dpulses++;
    end
    chk("t6_no_done", 64'(dpulses), 64'd0);
    issue(100, 2, 7);
    wait_idle();

    // Randomised tiles with random back-pressure.
    for (int i = 0; i < AMOD; i++) mem[i] = DW'($urandom);
    ready_mode = 1;
    for (int t = 0; t < 40; t++) begin
      issue(int'($urandom_range(0, AMOD - 1)), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 255)));
    end
    wait_idle();
    ready_mode = 0;
    repeat (3) @(negedge clk);
    chk("end_rows_left", 64'(exp_row_q.size()), 64'd0);
    chk("end_addrs_left", 64'(exp_addr_q.size()), 64'd0);
    chk("end_done_left", 64'(done_pending), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
